// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch definitions: FSM state encoding, PC increment and alignment helpers.
// The control-unit code imports the same package.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_FULL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_t;

   localparam logic [31:0] PC_INCR    = 32'd4;
   localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

   // Word-step the fetch address; wraps 32'hFFFF_FFFC -> 0 naturally.
   function automatic logic [31:0] next_pc(input logic [31:0] addr);
      return addr + PC_INCR;
   endfunction

   function automatic logic is_aligned(input logic [31:0] addr);
      return (addr & ALIGN_MASK) == 32'h0;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// Memory-request watchdog: down-counter loaded with TIMEOUT-1, Expired flags the
// TIMEOUT-th consecutive cycle of an unanswered request.
module fetch_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Run,
   input  logic Clear,
   output logic Expired
);

   localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

   logic [7:0] count;

   // Saturates at zero so Expired stays up if the FSM defers acting on it.
   always_ff @(posedge Clk) begin
      if (Rst || Clear) begin
         count <= LOAD;
      end else if (Run && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign Expired = Run && (count == 8'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetch PC, one-word prefetch buffer and the memory/IR handshake FSM.
//
//   state | meaning
//   REQ   | MemReq=1 at FetchPC, waiting for MemAck (MemReq=0 only right after reset: arm)
//   FULL  | prefetch buffer valid, waiting for FetchEn to deliver it
//   DRAIN | redirect arrived mid-request; hold MemReq until MemAck, discard the data
//   ERR   | timeout or misaligned redirect; MemReq=0, FetchErr=1
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        FetchEn,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemAck,
   input  logic [31:0] MemData,
   output logic [31:0] Instruction,
   output logic        IRWrite,
   output logic [31:0] PC,
   output logic        FetchErr
);

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  buf_word;
   logic [31:0]  buf_pc;
   logic         pending;
   logic         expired;
   logic         tmo_clear;
   logic [31:0]  drain_target;

   // Counter restarts whenever no request is outstanding or the memory answers.
   assign tmo_clear    = MemAck || !MemReq;
   assign drain_target = Redirect ? RedirectPC : fetch_pc;

   fetch_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .Clk     (Clk),
      .Rst     (Rst),
      .Run     (MemReq),
      .Clear   (tmo_clear),
      .Expired (expired)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= ST_REQ;
         MemReq      <= 1'b0;
         MemAddr     <= RESET_PC;
         fetch_pc    <= RESET_PC;
         buf_word    <= 32'h0;
         buf_pc      <= RESET_PC;
         pending     <= 1'b0;
         Instruction <= 32'h0;
         PC          <= RESET_PC;
         IRWrite     <= 1'b0;
         FetchErr    <= 1'b0;
      end else begin
         IRWrite <= 1'b0;
         case (state)
            ST_REQ: begin
               if (Redirect) begin
                  pending  <= 1'b0;
                  fetch_pc <= RedirectPC;
                  if (MemReq && !MemAck) begin
                     state <= ST_DRAIN;
                  end else if (!is_aligned(RedirectPC)) begin
                     state    <= ST_ERR;
                     MemReq   <= 1'b0;
                     FetchErr <= 1'b1;
                  end else begin
                     MemReq  <= 1'b1;
                     MemAddr <= RedirectPC;
                  end
               end else if (!MemReq) begin
                  MemReq  <= 1'b1;
                  MemAddr <= fetch_pc;
                  if (FetchEn) pending <= 1'b1;
               end else if (MemAck) begin
                  fetch_pc <= next_pc(fetch_pc);
                  if (pending || FetchEn) begin
                     Instruction <= MemData;
                     PC          <= fetch_pc;
                     IRWrite     <= 1'b1;
                     pending     <= 1'b0;
                     MemAddr     <= next_pc(fetch_pc);
                  end else begin
                     buf_word <= MemData;
                     buf_pc   <= fetch_pc;
                     MemReq   <= 1'b0;
                     state    <= ST_FULL;
                  end
               end else if (expired) begin
                  state    <= ST_ERR;
                  MemReq   <= 1'b0;
                  FetchErr <= 1'b1;
               end else if (FetchEn) begin
                  pending <= 1'b1;
               end
            end

            ST_FULL: begin
               if (Redirect) begin
                  pending  <= 1'b0;
                  fetch_pc <= RedirectPC;
                  if (!is_aligned(RedirectPC)) begin
                     state    <= ST_ERR;
                     FetchErr <= 1'b1;
                  end else begin
                     state   <= ST_REQ;
                     MemReq  <= 1'b1;
                     MemAddr <= RedirectPC;
                  end
               end else if (FetchEn) begin
                  Instruction <= buf_word;
                  PC          <= buf_pc;
                  IRWrite     <= 1'b1;
                  state       <= ST_REQ;
                  MemReq      <= 1'b1;
                  MemAddr     <= fetch_pc;
               end
            end

            ST_DRAIN: begin
               if (MemAck) begin
                  fetch_pc <= drain_target;
                  if (Redirect) pending <= 1'b0;
                  if (!is_aligned(drain_target)) begin
                     state    <= ST_ERR;
                     MemReq   <= 1'b0;
                     FetchErr <= 1'b1;
                  end else begin
                     state   <= ST_REQ;
                     MemAddr <= drain_target;
                  end
               end else if (expired) begin
                  state    <= ST_ERR;
                  MemReq   <= 1'b0;
                  FetchErr <= 1'b1;
               end else if (Redirect) begin
                  fetch_pc <= RedirectPC;
                  pending  <= 1'b0;
               end else if (FetchEn) begin
                  pending <= 1'b1;
               end
            end

            ST_ERR: begin
               MemReq   <= 1'b0;
               FetchErr <= 1'b1;
               if (Redirect && is_aligned(RedirectPC)) begin
                  FetchErr <= 1'b0;
                  pending  <= 1'b0;
                  fetch_pc <= RedirectPC;
                  state    <= ST_REQ;
                  MemReq   <= 1'b1;
                  MemAddr  <= RedirectPC;
               end
            end

            default: begin
               state  <= ST_REQ;
               MemReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cycle table with hand-computed outputs,
// then hand sequences for the request timeout and a misaligned redirect during DRAIN.
module tb_instruction_fetch_unit;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        FetchEn;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic [31:0] MemData;
   logic [31:0] Instruction;
   logic        IRWrite;
   logic [31:0] PC;
   logic        FetchErr;

   instruction_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (4)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .FetchEn     (FetchEn),
      .Redirect    (Redirect),
      .RedirectPC  (RedirectPC),
      .MemReq      (MemReq),
      .MemAddr     (MemAddr),
      .MemAck      (MemAck),
      .MemData     (MemData),
      .Instruction (Instruction),
      .IRWrite     (IRWrite),
      .PC          (PC),
      .FetchErr    (FetchErr)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst;
      logic        fe;
      logic        rd;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] data;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_irw;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic rst, input logic fe, input logic rd, input logic [31:0] rpc,
                      input logic ack, input logic [31:0] data,
                      input logic e_req, input logic [31:0] e_addr, input logic e_irw,
                      input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_err);
      vec_t v;
      v = '{rst, fe, rd, rpc, ack, data, e_req, e_addr, e_irw, e_instr, e_pc, e_err};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fe, input logic rd, input logic [31:0] rpc,
                        input logic ack, input logic [31:0] data);
      Rst        = rst;
      FetchEn    = fe;
      Redirect   = rd;
      RedirectPC = rpc;
      MemAck     = ack;
      MemData    = data;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int  seen;
      bit  got_err;

      //    rst fe rd rpc           ack data          req addr          irw instr         pc            err
      add(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        0); // 0 reset
      add(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        0); // 1
      add(0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        0); // 2 arm
      add(0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        0); // 3
      add(0, 1, 0, 32'h0,        1, 32'h8C22_0004, 1, 32'h4,         1, 32'h8C22_0004, 32'h0,        0); // 4 deliver
      add(0, 0, 0, 32'h0,        1, 32'h1111_0004, 0, 32'h4,         0, 32'h8C22_0004, 32'h0,        0); // 5 FULL @4
      add(0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h8,         1, 32'h1111_0004, 32'h4,        0); // 6
      add(0, 0, 0, 32'h0,        1, 32'h2222_0008, 0, 32'h8,         0, 32'h1111_0004, 32'h4,        0); // 7
      add(0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hC,         1, 32'h2222_0008, 32'h8,        0); // 8
      add(0, 0, 0, 32'h0,        1, 32'h3333_000C, 0, 32'hC,         0, 32'h2222_0008, 32'h8,        0); // 9
      add(0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h10,        1, 32'h3333_000C, 32'hC,        0); // 10
      add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h10,        0, 32'h3333_000C, 32'hC,        0); // 11
      add(0, 0, 1, 32'h40,       0, 32'h0,         1, 32'h10,        0, 32'h3333_000C, 32'hC,        0); // 12 DRAIN
      add(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h40,        0, 32'h3333_000C, 32'hC,        0); // 13 discard
      add(0, 0, 0, 32'h0,        1, 32'h4444_0040, 0, 32'h40,        0, 32'h3333_000C, 32'hC,        0); // 14 FULL
      add(0, 0, 1, 32'h42,       0, 32'h0,         0, 32'h40,        0, 32'h3333_000C, 32'hC,        1); // 15 misaligned
      add(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h40,        0, 32'h3333_000C, 32'hC,        1); // 16 sticky
      add(0, 0, 1, 32'h80,       0, 32'h0,         1, 32'h80,        0, 32'h3333_000C, 32'hC,        0); // 17 recover
      add(0, 1, 0, 32'h0,        1, 32'h5555_0080, 1, 32'h84,        1, 32'h5555_0080, 32'h80,       0); // 18
      add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h84,        0, 32'h5555_0080, 32'h80,       0); // 19
      add(0, 0, 0, 32'h0,        1, 32'h6666_0084, 0, 32'h84,        0, 32'h5555_0080, 32'h80,       0); // 20 FULL
      add(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h5555_0080, 32'h80,       0); // 21 redirect wins
      add(0, 1, 0, 32'h0,        1, 32'h7777_FFFC, 1, 32'h0,         1, 32'h7777_FFFC, 32'hFFFF_FFFC, 0); // 22 wrap
      add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h7777_FFFC, 32'hFFFF_FFFC, 0); // 23
      add(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        0); // 24 reset mid-req
      add(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        0); // 25 re-arm

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].fe, vecs[i].rd, vecs[i].rpc, vecs[i].ack, vecs[i].data);
         chk($sformatf("row%0d MemReq", i),      {31'h0, MemReq},   {31'h0, vecs[i].e_req});
         chk($sformatf("row%0d MemAddr", i),     MemAddr,           vecs[i].e_addr);
         chk($sformatf("row%0d IRWrite", i),     {31'h0, IRWrite},  {31'h0, vecs[i].e_irw});
         chk($sformatf("row%0d Instruction", i), Instruction,       vecs[i].e_instr);
         chk($sformatf("row%0d PC", i),          PC,                vecs[i].e_pc);
         chk($sformatf("row%0d FetchErr", i),    {31'h0, FetchErr}, {31'h0, vecs[i].e_err});
      end

      // Timeout: MemReq already high for one sampled cycle; withhold MemAck.
      seen    = 1;
      got_err = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive(0, 0, 0, 32'h0, 0, 32'h0);
         if (FetchErr) begin
            got_err = 1'b1;
            break;
         end
         if (MemReq) seen++;
      end
      chk("timeout FetchErr",      {31'h0, got_err}, 32'h1);
      chk("timeout req cycles",    32'(seen),        32'd4);
      chk("timeout MemReq",        {31'h0, MemReq},  32'h0);
      chk("timeout IRWrite",       {31'h0, IRWrite}, 32'h0);

      // Misaligned redirect while a request is outstanding: DRAIN first, then ERR.
      drive(0, 0, 1, 32'h80, 0, 32'h0);
      chk("recover MemReq",        {31'h0, MemReq},   32'h1);
      chk("recover MemAddr",       MemAddr,           32'h80);
      chk("recover FetchErr",      {31'h0, FetchErr}, 32'h0);
      drive(0, 0, 1, 32'h13, 0, 32'h0);
      chk("drain MemReq held",     {31'h0, MemReq},   32'h1);
      chk("drain MemAddr stable",  MemAddr,           32'h80);
      chk("drain FetchErr",        {31'h0, FetchErr}, 32'h0);
      drive(0, 1, 0, 32'h0, 1, 32'hBAD0_BAD0);
      chk("drain-err FetchErr",    {31'h0, FetchErr}, 32'h1);
      chk("drain-err MemReq",      {31'h0, MemReq},   32'h0);
      chk("drain-err IRWrite",     {31'h0, IRWrite},  32'h0);
      chk("drain-err Instruction", Instruction,       32'h0);

      drive(0, 0, 0, 32'h0, 0, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
